// File: rtl/mdc_twiddle_sched_if.sv
// Sample/twiddle handshake between an MDC lower-path source and its twiddle scheduler.
// The slave side is the scheduler; the master side drives the samples.
interface mdc_twiddle_sched_if #(
    parameter int unsigned N_LOG2 = 5,
    parameter int unsigned AW     = N_LOG2 - 1
);
    logic          in_valid;
    logic          frame_start;
    logic [2:0]    stage;
    logic [AW-1:0] rom_addr;
    logic          mul_mode;
    logic          out_valid;
    logic          frame_done;
    logic          overrun;

    modport master (
        output in_valid, frame_start, stage,
        input  rom_addr, mul_mode, out_valid, frame_done, overrun
    );

    modport slave (
        input  in_valid, frame_start, stage,
        output rom_addr, mul_mode, out_valid, frame_done, overrun
    );
endinterface

// File: rtl/mdc_twiddle_sched.sv
// Twiddle ROM address and multiplier bypass scheduler for one radix-2 DIF MDC stage.
// The stage index is captured on frame_start so a whole frame uses one twiddle sequence.
module mdc_twiddle_sched #(
    parameter int unsigned N_LOG2 = 5,
    parameter int unsigned AW     = N_LOG2 - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mdc_twiddle_sched_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [2:0]    stage_q;
    logic [AW-1:0] rom_addr_q;
    logic          mul_mode_q;
    logic          out_valid_q;
    logic          frame_done_q;
    logic          overrun_q;

    logic          restart_d;
    logic          accept_d;
    logic [AW-1:0] n_d;
    logic [2:0]    s_d;
    logic [AW-1:0] e_d;
    logic          mm_d;
    logic          last_d;

    // Masking n to the low AW-s bits and shifting by s is the same as
    // shifting n by s and dropping everything above AW bits.
    always_comb begin
        restart_d = bus.in_valid & bus.frame_start;
        accept_d  = restart_d | (bus.in_valid & (state_q == RUN));
        n_d       = restart_d ? '0 : cnt_q;
        s_d       = restart_d ? bus.stage : stage_q;
        last_d    = &n_d;
        e_d       = '0;
        mm_d      = 1'b1;
        if (32'(s_d) < N_LOG2 - 1) begin
            e_d  = n_d << s_d;
            mm_d = (e_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stage_q      <= '0;
            rom_addr_q   <= '0;
            mul_mode_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            out_valid_q  <= accept_d;
            frame_done_q <= accept_d & last_d;
            if (accept_d) begin
                rom_addr_q <= e_d;
                mul_mode_q <= mm_d;
            end
            if (restart_d) begin
                if ((state_q == RUN) && (cnt_q != '0)) begin
                    overrun_q <= 1'b1;
                end
                stage_q <= bus.stage;
                cnt_q   <= AW'(1);
                state_q <= RUN;
            end else if (accept_d) begin
                if (last_d) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.mul_mode   = mul_mode_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_mdc_twiddle_sched.sv
// Directed and randomized bench for mdc_twiddle_sched against a frame-level reference model.
module tb_mdc_twiddle_sched;
    localparam int N_LOG2 = 5;
    localparam int AWI    = N_LOG2 - 1;
    localparam int FRAME  = 1 << AWI;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: frame position and expected registered outputs.
    bit m_run;
    int m_cnt;
    int m_stg;
    bit m_ovr;
    int e_addr;
    bit e_mm;
    bit e_valid;
    bit e_done;
    bit e_ovr;
    int last_n;

    mdc_twiddle_sched_if #(.N_LOG2(N_LOG2), .AW(AWI)) bus ();

    mdc_twiddle_sched #(.N_LOG2(N_LOG2), .AW(AWI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rom_addr",   32'(bus.rom_addr),   32'(e_addr));
        chk("mul_mode",   32'(bus.mul_mode),   32'(e_mm));
        chk("out_valid",  32'(bus.out_valid),  32'(e_valid));
        chk("frame_done", 32'(bus.frame_done), 32'(e_done));
        chk("overrun",    32'(bus.overrun),    32'(e_ovr));
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_stg = 0; m_ovr = 0;
        e_addr = 0; e_mm = 1; e_valid = 0; e_done = 0; e_ovr = 0; last_n = -1;
    endtask

    task automatic model_step(input bit v, input bit fs, input int st);
        int n;
        int j;
        bit took;
        took = 0;
        n    = 0;
        if (v && fs) begin
            if (m_run && m_cnt != 0) m_ovr = 1;
            m_stg = st; n = 0; m_cnt = 1; m_run = 1; took = 1;
        end else if (v && m_run) begin
            n = m_cnt; took = 1;
            if (n == FRAME - 1) begin m_cnt = 0; m_run = 0; end
            else m_cnt = m_cnt + 1;
        end
        e_valid = took;
        e_done  = took && (n == FRAME - 1);
        if (took) begin
            last_n = n;
            if (m_stg >= N_LOG2 - 1) begin
                e_addr = 0; e_mm = 1;
            end else begin
                j      = n % (1 << (AWI - m_stg));
                e_addr = (j << m_stg) % FRAME;
                e_mm   = (e_addr == 0);
            end
        end
        e_ovr = m_ovr;
    endtask

    task automatic step(input bit v, input bit fs, input int st);
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.stage       = 3'(st);
        model_step(v, fs, st);
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic run_frame(input int st);
        for (int i = 0; i < FRAME; i++)
            step(1'b1, i == 0, (i == 0) ? st : int'($urandom_range(0, 7)));
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.stage       = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Samples without frame_start while idle are dropped.
        step(1, 0, 2);
        step(1, 0, 1);

        run_frame(0);
        step(0, 0, 0);
        step(0, 0, 0);
        // Back-to-back frames: no idle gap, no overrun.
        run_frame(1);
        run_frame(3);
        run_frame(4);
        step(0, 0, 0);

        // Stage 2 with a 3-cycle stall after n=5 and stage input changed mid-frame.
        for (int i = 0; i < 6; i++) step(1, i == 0, (i == 0) ? 2 : 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 0);
        chk("stall_resume_addr", 32'(bus.rom_addr), 32'd8);
        for (int i = 7; i < FRAME; i++) step(1, 0, 0);

        // Premature frame_start where n=7 would be: sticky overrun, restart.
        for (int i = 0; i < 7; i++) step(1, i == 0, 1);
        step(1, 1, 0);
        chk("restart_addr", 32'(bus.rom_addr), 32'd0);
        chk("overrun_set",  32'(bus.overrun),  32'd1);
        for (int i = 1; i < 10; i++) step(1, 0, 0);
        chk("pre_reset_n", 32'(last_n), 32'd9);

        // Asynchronous reset mid-frame.
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1);
        step(1, 0, 0);
        run_frame(2);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 6,
                 int'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
